// File: rtl/zvc_pkg.sv
// Shared constants and types for the zero-value compressor and its line packer.
package zvc_pkg;
  localparam int LANES         = 128;
  localparam int WORD_WIDTH    = 8;
  localparam int DIST_WIDTH    = 7;
  localparam int MAX_LIFM_RSIZ = 4;
  localparam int CNT_WIDTH     = 8;
  localparam int LVL_WIDTH     = CNT_WIDTH + 1;
  localparam int IDX_WIDTH     = $clog2(LANES);
  localparam int MT_WIDTH      = DIST_WIDTH * MAX_LIFM_RSIZ;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] lifm;
    logic [MT_WIDTH-1:0]   mt;
  } zvc_entry_t;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } zvc_state_e;

  // Entries available for one output beat: min(lvl, LANES).
  function automatic logic [CNT_WIDTH-1:0] zvc_min_lanes(input logic [LVL_WIDTH-1:0] lvl);
    return (lvl >= LVL_WIDTH'(LANES)) ? CNT_WIDTH'(LANES) : lvl[CNT_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/zvc_line_packer_if.sv
// Compressed-line input and packed-beat output handshakes of the line packer.
interface zvc_line_packer_if;
  import zvc_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic [LANES*WORD_WIDTH-1:0]   lifm_comp;
  logic [LANES*MT_WIDTH-1:0]     mt_comp;

  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*WORD_WIDTH-1:0]   lifm_pack;
  logic [LANES*MT_WIDTH-1:0]     mt_pack;
  logic [CNT_WIDTH-1:0]          out_cnt;
  logic                          out_last;

  modport master (
    output in_valid, in_last, lifm_comp, mt_comp, out_ready,
    input  in_ready, out_valid, lifm_pack, mt_pack, out_cnt, out_last
  );

  modport slave (
    input  in_valid, in_last, lifm_comp, mt_comp, out_ready,
    output in_ready, out_valid, lifm_pack, mt_pack, out_cnt, out_last
  );
endinterface

// File: rtl/zvc_popcount128.sv
// 128-bit mask population count as a balanced combinational adder tree.
module zvc_popcount128
  import zvc_pkg::*;
(
  input  logic [LANES-1:0]     i_mask,
  output logic [CNT_WIDTH-1:0] o_cnt
);
  logic [2:0] w_l0 [32];
  logic [3:0] w_l1 [16];
  logic [4:0] w_l2 [8];
  logic [5:0] w_l3 [4];
  logic [6:0] w_l4 [2];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_l0[i] = 3'(i_mask[4*i]) + 3'(i_mask[4*i+1]) + 3'(i_mask[4*i+2]) + 3'(i_mask[4*i+3]);
    end
    for (int i = 0; i < 16; i++) w_l1[i] = 4'(w_l0[2*i]) + 4'(w_l0[2*i+1]);
    for (int i = 0; i < 8; i++)  w_l2[i] = 5'(w_l1[2*i]) + 5'(w_l1[2*i+1]);
    for (int i = 0; i < 4; i++)  w_l3[i] = 6'(w_l2[2*i]) + 6'(w_l2[2*i+1]);
    for (int i = 0; i < 2; i++)  w_l4[i] = 7'(w_l3[2*i]) + 7'(w_l3[2*i+1]);
    o_cnt = CNT_WIDTH'(w_l4[0]) + CNT_WIDTH'(w_l4[1]);
  end
endmodule

// File: rtl/zvc_line_packer.sv
// Packs variable-length compressed lines into dense 128-entry beats; frame end drains the residue.
// Optional contiguity checker and err port enabled by `define ZVC_PACKER_CHECK_EN.
module zvc_line_packer
  import zvc_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  zvc_line_packer_if.slave   bus
`ifdef ZVC_PACKER_CHECK_EN
  ,
  output logic               err
`endif
);
  localparam int LW = LANES * WORD_WIDTH;
  localparam int LM = LANES * MT_WIDTH;

  zvc_state_e           r_state;
  logic [LVL_WIDTH-1:0] r_lvl;
  logic [2*LW-1:0]      r_lifm;
  logic [2*LM-1:0]      r_mt;

  logic [LANES-1:0]     w_nz;
  logic [LANES-1:0]     w_keep;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic [2*LW-1:0]      w_lifm_in;
  logic [2*LM-1:0]      w_mt_in;
  logic [2*LW-1:0]      w_lifm_shift;
  logic [2*LM-1:0]      w_mt_shift;
  logic [2*LW-1:0]      w_lifm_app;
  logic [2*LM-1:0]      w_mt_app;
  logic [LVL_WIDTH-1:0] w_lvl_shift;
  logic [IDX_WIDTH-1:0] w_base;
  logic                 w_out_valid;
  logic                 w_out_last;
  logic                 w_out_fire;
  logic                 w_in_ready;
  logic                 w_in_fire;

  zvc_popcount128 u_popcount (
    .i_mask (w_nz),
    .o_cnt  (w_cnt)
  );

  assign w_out_valid = (r_lvl >= LVL_WIDTH'(LANES)) | (r_state == FLUSH);
  assign w_out_last  = (r_state == FLUSH) & (r_lvl <= LVL_WIDTH'(LANES));
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_in_ready  = (r_state == FILL) & ((r_lvl < LVL_WIDTH'(LANES)) | bus.out_ready);
  assign w_in_fire   = bus.in_valid & w_in_ready;

  // Lane valid mask from nonzero MT entries; only the first cnt lanes are appended.
  always_comb begin
    w_nz      = '0;
    w_keep    = '0;
    w_lifm_in = '0;
    w_mt_in   = '0;
    for (int i = 0; i < LANES; i++) begin
      w_nz[i] = |bus.mt_comp[i*MT_WIDTH +: MT_WIDTH];
    end
    for (int i = 0; i < LANES; i++) begin
      w_keep[i] = (CNT_WIDTH'(i) < w_cnt);
      w_lifm_in[i*WORD_WIDTH +: WORD_WIDTH] =
        bus.lifm_comp[i*WORD_WIDTH +: WORD_WIDTH] & {WORD_WIDTH{w_keep[i]}};
      w_mt_in[i*MT_WIDTH +: MT_WIDTH] =
        bus.mt_comp[i*MT_WIDTH +: MT_WIDTH] & {MT_WIDTH{w_keep[i]}};
    end
  end

  // Drain first, then append at the post-drain level; the tail above lvl is always zero,
  // so the append can be merged with a plain OR.
  assign w_lifm_shift = w_out_fire ? {{LW{1'b0}}, r_lifm[2*LW-1:LW]} : r_lifm;
  assign w_mt_shift   = w_out_fire ? {{LM{1'b0}}, r_mt[2*LM-1:LM]}   : r_mt;
  assign w_lvl_shift  = w_out_fire ? (r_lvl - LVL_WIDTH'(zvc_min_lanes(r_lvl))) : r_lvl;
  assign w_base       = w_lvl_shift[IDX_WIDTH-1:0];
  assign w_lifm_app   = w_lifm_in << (int'(w_base) * WORD_WIDTH);
  assign w_mt_app     = w_mt_in << (int'(w_base) * MT_WIDTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILL;
      r_lvl   <= '0;
      r_lifm  <= '0;
      r_mt    <= '0;
    end else begin
      if (w_out_fire || w_in_fire) begin
        r_lifm <= w_lifm_shift | (w_in_fire ? w_lifm_app : '0);
        r_mt   <= w_mt_shift   | (w_in_fire ? w_mt_app   : '0);
      end
      case (r_state)
        FILL: begin
          r_lvl <= w_lvl_shift + (w_in_fire ? LVL_WIDTH'(w_cnt) : '0);
          if (w_in_fire && bus.in_last) r_state <= FLUSH;
        end
        FLUSH: begin
          if (w_out_fire && w_out_last) begin
            r_lvl   <= '0;
            r_state <= FILL;
          end else begin
            r_lvl <= w_lvl_shift;
          end
        end
        default: begin
          r_lvl   <= '0;
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.out_cnt   = zvc_min_lanes(r_lvl);
  assign bus.lifm_pack = r_lifm[LW-1:0];
  assign bus.mt_pack   = r_mt[LM-1:0];

`ifdef ZVC_PACKER_CHECK_EN
  logic r_err;
  logic w_gap;

  // A valid entry sitting above a bubble means the compressor broke contiguity.
  assign w_gap = |(w_nz[LANES-1:1] & ~w_nz[LANES-2:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else if (w_in_fire && w_gap) r_err <= 1'b1;
  end

  assign err = r_err;
`endif
endmodule

// File: tb/tb_zvc_line_packer.sv
// Directed bench for zvc_line_packer: framing, partial beats, back-pressure and async reset.
module tb_zvc_line_packer;
  import zvc_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  zvc_line_packer_if bus();

`ifdef ZVC_PACKER_CHECK_EN
  logic err;
`endif

  zvc_line_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ZVC_PACKER_CHECK_EN
    ,
    .err     (err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xl(input logic [7:0] tag, input int i);
    return tag + 8'(i);
  endfunction

  function automatic logic [27:0] xm(input logic [7:0] tag, input int i);
    return {4'h1, tag, 16'(i)};
  endfunction

  function automatic logic [7:0] lifm_at(input int i);
    return bus.lifm_pack[i*8 +: 8];
  endfunction

  function automatic logic [27:0] mt_at(input int i);
    return bus.mt_pack[i*28 +: 28];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lanes past cnt carry junk LIFM data with zero MT so masking is exercised.
  task automatic drive_line(input int cnt, input logic [7:0] tag, input logic last);
    logic [LANES*8-1:0]  l;
    logic [LANES*28-1:0] m;
    for (int i = 0; i < LANES; i++) begin
      if (i < cnt) begin
        l[i*8 +: 8]   = xl(tag, i);
        m[i*28 +: 28] = xm(tag, i);
      end else begin
        l[i*8 +: 8]   = 8'hEE;
        m[i*28 +: 28] = '0;
      end
    end
    bus.lifm_comp = l;
    bus.mt_comp   = m;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  logic [35:0] acc;

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.lifm_comp = '0;
    bus.mt_comp   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_cnt", 64'(bus.out_cnt), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_lifm_zero", 64'(|bus.lifm_pack), 64'd0);
    check("rst_mt_zero", 64'(|bus.mt_pack), 64'd0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Two full lines, second closes the frame
    step();
    drive_line(128, 8'h10, 1'b0);
    #1;
    check("t1_in_ready_a", 64'(bus.in_ready), 64'd1);
    step();
    check("t1_b1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_b1_cnt", 64'(bus.out_cnt), 64'd128);
    check("t1_b1_last", 64'(bus.out_last), 64'd0);
    check("t1_b1_e0", 64'(lifm_at(0)), 64'(xl(8'h10, 0)));
    check("t1_b1_mt127", 64'(mt_at(127)), 64'(xm(8'h10, 127)));
    drive_line(128, 8'h30, 1'b1);
    #1;
    check("t1_in_ready_b", 64'(bus.in_ready), 64'd1);
    step();
    idle();
    check("t1_b2_valid", 64'(bus.out_valid), 64'd1);
    check("t1_b2_cnt", 64'(bus.out_cnt), 64'd128);
    check("t1_b2_last", 64'(bus.out_last), 64'd1);
    check("t1_b2_e0", 64'(lifm_at(0)), 64'(xl(8'h30, 0)));
    check("t1_b2_e127", 64'(lifm_at(127)), 64'hAF);
    step();
    check("t1_done_valid", 64'(bus.out_valid), 64'd0);
    check("t1_done_in_ready", 64'(bus.in_ready), 64'd1);

    // 100 + 100 entries: one full beat plus a 72-entry tail
    drive_line(100, 8'h20, 1'b0);
    step();
    check("t2_partial_valid", 64'(bus.out_valid), 64'd0);
    check("t2_partial_cnt", 64'(bus.out_cnt), 64'd100);
    drive_line(100, 8'h40, 1'b1);
    step();
    idle();
    check("t2_b1_cnt", 64'(bus.out_cnt), 64'd128);
    check("t2_b1_last", 64'(bus.out_last), 64'd0);
    check("t2_b1_e99", 64'(lifm_at(99)), 64'(xl(8'h20, 99)));
    check("t2_b1_e100", 64'(lifm_at(100)), 64'h40);
    check("t2_b1_e127", 64'(lifm_at(127)), 64'h5B);
    check("t2_b1_mt127", 64'(mt_at(127)), 64'(xm(8'h40, 27)));
    step();
    check("t2_b2_valid", 64'(bus.out_valid), 64'd1);
    check("t2_b2_cnt", 64'(bus.out_cnt), 64'd72);
    check("t2_b2_last", 64'(bus.out_last), 64'd1);
    check("t2_b2_e0", 64'(lifm_at(0)), 64'h5C);
    check("t2_b2_e71", 64'(lifm_at(71)), 64'hA3);
    check("t2_b2_mt71", 64'(mt_at(71)), 64'(xm(8'h40, 99)));
    acc = '0;
    for (int i = 72; i < LANES; i++) acc = acc | {lifm_at(i), mt_at(i)};
    check("t2_b2_tail_zero", 64'(acc), 64'd0);
    step();
    check("t2_done_valid", 64'(bus.out_valid), 64'd0);

    // Empty frame: one empty last beat
    drive_line(0, 8'h00, 1'b1);
    step();
    idle();
    check("t3_valid", 64'(bus.out_valid), 64'd1);
    check("t3_cnt", 64'(bus.out_cnt), 64'd0);
    check("t3_last", 64'(bus.out_last), 64'd1);
    check("t3_lifm_zero", 64'(|bus.lifm_pack), 64'd0);
    check("t3_mt_zero", 64'(|bus.mt_pack), 64'd0);
    check("t3_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("t3_done_valid", 64'(bus.out_valid), 64'd0);

    // Back-pressure for 5 cycles with full lines offered every cycle
    bus.out_ready = 1'b0;
    drive_line(128, 8'h60, 1'b0);
    step();
    drive_line(128, 8'h70, 1'b1);
    #1;
    check("t4_in_ready_low", 64'(bus.in_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("t4_stall_hold_e5", 64'(lifm_at(5)), 64'(xl(8'h60, 5)));
      check("t4_stall_last", 64'(bus.out_last), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4_release_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    idle();
    check("t4_b2_last", 64'(bus.out_last), 64'd1);
    check("t4_b2_e5", 64'(lifm_at(5)), 64'(xl(8'h70, 5)));
    check("t4_b2_mt127", 64'(mt_at(127)), 64'(xm(8'h70, 127)));
    step();
    check("t4_done_valid", 64'(bus.out_valid), 64'd0);

    // Async reset mid-frame with lvl=60
    drive_line(60, 8'h80, 1'b0);
    step();
    idle();
    check("t5_pre_cnt", 64'(bus.out_cnt), 64'd60);
    check("t5_pre_e0", 64'(lifm_at(0)), 64'h80);
    reset_n = 1'b0;
    #1;
    check("t5_rst_cnt", 64'(bus.out_cnt), 64'd0);
    check("t5_rst_lifm_zero", 64'(|bus.lifm_pack), 64'd0);
    check("t5_rst_mt_zero", 64'(|bus.mt_pack), 64'd0);
    check("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    drive_line(128, 8'h90, 1'b1);
    step();
    idle();
    check("t5_next_cnt", 64'(bus.out_cnt), 64'd128);
    check("t5_next_last", 64'(bus.out_last), 64'd1);
    check("t5_next_e0", 64'(lifm_at(0)), 64'h90);
    check("t5_next_e60", 64'(lifm_at(60)), 64'hCC);
    step();
    check("t5_done_valid", 64'(bus.out_valid), 64'd0);

`ifdef ZVC_PACKER_CHECK_EN
    // Non-contiguous line: entry 3 valid above a bubble at entry 2
    check("t6_err_pre", 64'(err), 64'd0);
    bus.lifm_comp = '0;
    bus.mt_comp   = '0;
    bus.mt_comp[0*28 +: 28] = 28'h1;
    bus.mt_comp[1*28 +: 28] = 28'h2;
    bus.mt_comp[3*28 +: 28] = 28'h3;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    step();
    idle();
    check("t6_err_set", 64'(err), 64'd1);
    check("t6_cnt_popcount", 64'(bus.out_cnt), 64'd3);
    repeat (3) step();
    check("t6_err_sticky", 64'(err), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_err_reset", 64'(err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
